// File: rtl/ss_scan_driver_pkg.sv
// ss_pkg: shared constants and helpers for the multiplexed 7-segment scan driver.
//   SEG_BLANK : all segments off (active-low).
//   SEG_LUT   : hex nibble -> active-low segments {a,b,c,d,e,f,g}, indexed by nibble.
//   clog2     : counter width helper for localparams; never returns less than 1.
package ss_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Leftmost entry is nibble F, rightmost is nibble 0.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  // Width needed to count 0..value-1, with a floor of one bit so that
  // degenerate counters still get a legal declaration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ss_scan_driver_if.sv
// ss_scan_driver_if: application-side register bus and board pin bundle.
//   data/mask/dp/blink/lzs_en/bright/load : from application logic into the driver
//   ssA..ssG, ssDP, an                    : active-low segment and anode pins
//   frame_tick                            : one-cycle pulse on the frame boundary
// The master modport is the application/board side; the slave modport is the driver.
interface ss_scan_driver_if #(
  parameter int N_DIGITS = 8,
  parameter int BRIGHT_W = 3
);

  logic [4*N_DIGITS-1:0] data;
  logic [N_DIGITS-1:0]   mask;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blink;
  logic                  lzs_en;
  logic [BRIGHT_W-1:0]   bright;
  logic                  load;

  logic                  ssA, ssB, ssC, ssD, ssE, ssF, ssG;
  logic                  ssDP;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_tick;

  modport master (
    output data, mask, dp, blink, lzs_en, bright, load,
    input  ssA, ssB, ssC, ssD, ssE, ssF, ssG, ssDP, an, frame_tick
  );

  modport slave (
    input  data, mask, dp, blink, lzs_en, bright, load,
    output ssA, ssB, ssC, ssD, ssE, ssF, ssG, ssDP, an, frame_tick
  );

endinterface

// File: rtl/ss_scan_driver_decoder.sv
// ss_decoder: combinational hex nibble to active-low 7-segment pattern.
//   nibble_i : hex digit value
//   seg_o    : {a,b,c,d,e,f,g}, 0 = segment lit
module ss_decoder
  import ss_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/ss_scan_driver.sv
// ss_scan_driver: multiplexed common-anode 7-segment scan driver.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of ss_scan_driver_if (register inputs, segment/anode pins)
// Each digit owns a slot of SCAN_DIV clocks; a frame is N_DIGITS slots. Register
// inputs are captured into shadow copies only on the frame boundary so a frame
// never shows a mix of old and new values. Brightness is live and gates the anode
// to the first (bright+1) of 2**BRIGHT_W equal subslots of each slot.
module ss_scan_driver
  import ss_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 64
) (
  input logic             clk,
  input logic             rst,
  ss_scan_driver_if.slave bus
);

  localparam int CNT_W   = clog2(SCAN_DIV);
  localparam int SEL_W   = clog2(N_DIGITS);
  localparam int SUB_LEN = SCAN_DIV / (1 << BRIGHT_W);
  localparam int SUB_W   = clog2(SUB_LEN);
  localparam int FRM_W   = clog2(BLINK_FRAMES);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_DIGITS - 1);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUB_LEN - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SUB_W-1:0]      sub_cnt_q, sub_cnt_d;
  logic [BRIGHT_W-1:0]   sub_idx_q, sub_idx_d;
  logic [FRM_W-1:0]      frm_cnt_q, frm_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  load_pend_q, load_pend_d;

  logic [4*N_DIGITS-1:0] data_q, data_d;
  logic [N_DIGITS-1:0]   mask_q, mask_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [N_DIGITS-1:0]   blink_q, blink_d;
  logic                  lzs_q, lzs_d;

  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  ssdp_q, ssdp_d;

  logic                  slot_end;
  logic                  frame_end;
  logic                  zero_run;
  logic [N_DIGITS-1:0]   lzs_supp;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_seg;
  logic                  pwm_on;
  logic                  guard;
  logic                  lit;

  // Slot counter, digit select and the PWM sub-counter. The sub-counter is
  // restarted on every slot wrap so its subslots stay aligned to the slot.
  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    frame_end = slot_end && (sel_q == SEL_MAX);
    cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
    sel_d     = sel_q;
    if (slot_end) begin
      sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
    end
    sub_cnt_d = sub_cnt_q + SUB_W'(1);
    sub_idx_d = sub_idx_q;
    if (slot_end) begin
      sub_cnt_d = '0;
      sub_idx_d = '0;
    end else if (sub_cnt_q == SUB_MAX) begin
      sub_cnt_d = '0;
      sub_idx_d = sub_idx_q + BRIGHT_W'(1);
    end
  end

  // Shadow registers and the pending-load flag. A load strobe arriving in the
  // boundary cycle itself is honoured directly, without waiting a frame.
  always_comb begin
    load_pend_d = load_pend_q | bus.load;
    data_d      = data_q;
    mask_d      = mask_q;
    dp_d        = dp_q;
    blink_d     = blink_q;
    lzs_d       = lzs_q;
    if (frame_end) begin
      load_pend_d = 1'b0;
      if (load_pend_q || bus.load) begin
        data_d  = bus.data;
        mask_d  = bus.mask;
        dp_d    = bus.dp;
        blink_d = bus.blink;
        lzs_d   = bus.lzs_en;
      end
    end
  end

  // Blink timebase: counts whole frames and flips the phase on each wrap.
  always_comb begin
    frm_cnt_d     = frm_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (frm_cnt_q == FRM_MAX) begin
        frm_cnt_d     = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frm_cnt_d = frm_cnt_q + FRM_W'(1);
      end
    end
  end

  // Leading-zero suppression, scanned from the most significant digit down.
  // Masked digits are treated as zero; digit 0 always stays visible.
  always_comb begin
    zero_run = 1'b1;
    lzs_supp = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run & ((data_q[4*i +: 4] == 4'h0) | ~mask_q[i]);
      lzs_supp[i] = lzs_q & zero_run & (i != 0);
    end
  end

  assign cur_nibble = data_q[{sel_q, 2'b00} +: 4];

  ss_decoder u_decoder (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  // Lit decision and output next-state. The cnt==0 guard blanks the first cycle
  // of every slot so the previous digit's pattern never ghosts onto the new anode.
  always_comb begin
    pwm_on = (sub_idx_q <= bus.bright);
    guard  = (cnt_q == '0);
    lit    = mask_q[sel_q] & ~lzs_supp[sel_q] & ~(blink_q[sel_q] & blink_phase_q)
             & pwm_on & ~guard;
    an_d   = '1;
    seg_d  = SEG_BLANK;
    ssdp_d = 1'b1;
    if (lit) begin
      an_d[sel_q] = 1'b0;
      seg_d       = cur_seg;
      ssdp_d      = ~dp_q[sel_q];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      sel_q         <= '0;
      sub_cnt_q     <= '0;
      sub_idx_q     <= '0;
      frm_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
      load_pend_q   <= 1'b0;
      data_q        <= '0;
      mask_q        <= '0;
      dp_q          <= '0;
      blink_q       <= '0;
      lzs_q         <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      ssdp_q        <= 1'b1;
    end else begin
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      sub_cnt_q     <= sub_cnt_d;
      sub_idx_q     <= sub_idx_d;
      frm_cnt_q     <= frm_cnt_d;
      blink_phase_q <= blink_phase_d;
      load_pend_q   <= load_pend_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      dp_q          <= dp_d;
      blink_q       <= blink_d;
      lzs_q         <= lzs_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      ssdp_q        <= ssdp_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.ssA        = seg_q[6];
  assign bus.ssB        = seg_q[5];
  assign bus.ssC        = seg_q[4];
  assign bus.ssD        = seg_q[3];
  assign bus.ssE        = seg_q[2];
  assign bus.ssF        = seg_q[1];
  assign bus.ssG        = seg_q[0];
  assign bus.ssDP       = ssdp_q;
  assign bus.frame_tick = frame_end;

endmodule

// File: tb/tb_ss_scan_driver.sv
// tb_ss_scan_driver: directed self-checking bench for ss_scan_driver with
// N_DIGITS=4, SCAN_DIV=8, BRIGHT_W=2, BLINK_FRAMES=2 (one frame = 32 clocks).
// The bench keeps its own cycle count since reset and derives slot, digit,
// subslot and blink phase from it; outputs are sampled on the falling edge and
// reflect the state of the previous cycle.
module tb_ss_scan_driver;

  localparam int N_DIGITS     = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BRIGHT_W     = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = N_DIGITS * SCAN_DIV;
  localparam int SUB_LEN      = SCAN_DIV / (1 << BRIGHT_W);

  logic clk = 1'b0;
  logic rst = 1'b1;

  ss_scan_driver_if #(.N_DIGITS(N_DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

  ss_scan_driver #(
    .N_DIGITS     (N_DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BRIGHT_W     (BRIGHT_W),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  int tbCycle = 0;

  // Cycles since the last reset; equals the driver's position within its scan.
  always @(posedge clk) begin
    if (rst) tbCycle <= 0;
    else     tbCycle <= tbCycle + 1;
  end

  int assertCount = 0;
  int failCount   = 0;

  logic [15:0] curData, nextData;
  logic [3:0]  curMask, nextMask, curDp, nextDp, curBlink, nextBlink;
  logic        curLzs, nextLzs;
  bit          nextValid;
  logic [1:0]  brightLevel;

  // Active-high {a,b,c,d,e,f,g} for hex digits 0..F.
  logic [6:0] hexSegOn [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Expected {an, segments, dp} visible during cycle cyc.
  function automatic logic [11:0] expectedOut(input int cyc);
    int p, s, c;
    logic supp, lit, phase;
    logic [3:0] an;
    logic [6:0] seg;
    logic dpo;
    an  = 4'hF;
    seg = 7'h7F;
    dpo = 1'b1;
    if (cyc > 0) begin
      p     = cyc - 1;
      s     = (p / SCAN_DIV) % N_DIGITS;
      c     = p % SCAN_DIV;
      phase = (((p / FRAME_LEN) / BLINK_FRAMES) % 2) == 1;
      supp  = 1'b0;
      if (curLzs && s != 0) begin
        supp = 1'b1;
        for (int k = s; k < N_DIGITS; k++) begin
          if (curMask[k] && curData[4*k +: 4] != 4'h0) supp = 1'b0;
        end
      end
      lit = curMask[s] && !supp && !(curBlink[s] && phase) &&
            ((c / SUB_LEN) <= int'(brightLevel)) && (c != 0);
      if (lit) begin
        an  = ~(4'b0001 << s);
        seg = ~hexSegOn[curData[4*s +: 4]];
        dpo = ~curDp[s];
      end
    end
    return {an, seg, dpo};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s at cycle %0d: observed %h, expected %h",
             tag, tbCycle, observed, expected);
    end
  endtask

  // Samples n consecutive cycles; the shadow model switches to a pending load
  // right after the sample that still shows the last cycle of the old frame.
  task automatic checkCycles(input int n);
    logic [11:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = expectedOut(tbCycle);
      checkOutput("anodes", {4'h0, bus.an}, {4'h0, e[11:8]});
      checkOutput("segments", {bus.ssA, bus.ssB, bus.ssC, bus.ssD, bus.ssE,
                               bus.ssF, bus.ssG, bus.ssDP}, e[7:0]);
      checkOutput("frame_tick", {7'h0, bus.frame_tick},
                  {7'h0, (tbCycle % FRAME_LEN) == FRAME_LEN - 1});
      if ((tbCycle % FRAME_LEN) == 0 && nextValid) begin
        curData   = nextData;
        curMask   = nextMask;
        curDp     = nextDp;
        curBlink  = nextBlink;
        curLzs    = nextLzs;
        nextValid = 1'b0;
      end
    end
  endtask

  // Drives new register values with a one-cycle load strobe, then checks up to
  // the frame boundary where they take effect.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] m,
                               input logic [3:0] p, input logic [3:0] b,
                               input logic l);
    bus.data   = d;
    bus.mask   = m;
    bus.dp     = p;
    bus.blink  = b;
    bus.lzs_en = l;
    bus.load   = 1'b1;
    nextData   = d;
    nextMask   = m;
    nextDp     = p;
    nextBlink  = b;
    nextLzs    = l;
    nextValid  = 1'b1;
    checkCycles(1);
    bus.load = 1'b0;
    checkCycles((FRAME_LEN - (tbCycle % FRAME_LEN)) % FRAME_LEN);
  endtask

  task automatic setBright(input logic [1:0] level);
    bus.bright  = level;
    brightLevel = level;
  endtask

  // Directed scenario sequence.
  initial begin
    bus.data   = '0;
    bus.mask   = '0;
    bus.dp     = '0;
    bus.blink  = '0;
    bus.lzs_en = 1'b0;
    bus.load   = 1'b0;
    setBright(2'd3);
    curData   = '0;
    curMask   = '0;
    curDp     = '0;
    curBlink  = '0;
    curLzs    = 1'b0;
    nextData  = '0;
    nextMask  = '0;
    nextDp    = '0;
    nextBlink = '0;
    nextLzs   = 1'b0;
    nextValid = 1'b0;

    $display("[TB] reset held for 3 clocks");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset anodes", {4'h0, bus.an}, 8'h0F);
    checkOutput("reset segments", {bus.ssA, bus.ssB, bus.ssC, bus.ssD, bus.ssE,
                                   bus.ssF, bus.ssG, bus.ssDP}, 8'hFF);
    checkOutput("reset frame_tick", {7'h0, bus.frame_tick}, 8'h00);
    rst = 1'b0;

    $display("[TB] no digit lit before the first load");
    checkCycles(40);

    $display("[TB] mid-frame load of 12AF, shown from the next frame");
    applyStimulus(16'h12AF, 4'hF, 4'b0010, 4'b0000, 1'b0);
    checkCycles(FRAME_LEN);

    $display("[TB] leading-zero suppression");
    applyStimulus(16'h0050, 4'hF, 4'b0000, 4'b0000, 1'b1);
    checkCycles(FRAME_LEN);
    applyStimulus(16'h0000, 4'hF, 4'b0000, 4'b0000, 1'b1);
    checkCycles(FRAME_LEN);

    $display("[TB] brightness levels 0 and 1");
    applyStimulus(16'h12AF, 4'hF, 4'b0000, 4'b0000, 1'b0);
    setBright(2'd0);
    checkCycles(FRAME_LEN);
    setBright(2'd1);
    checkCycles(FRAME_LEN);
    setBright(2'd3);

    $display("[TB] blink on digit 0");
    applyStimulus(16'h12AF, 4'hF, 4'b0000, 4'b0001, 1'b0);
    checkCycles(4 * FRAME_LEN);

    $display("[TB] load on the frame_tick cycle");
    checkCycles(FRAME_LEN - 1);
    bus.data   = 16'h3333;
    bus.blink  = 4'b0000;
    bus.load   = 1'b1;
    nextData   = 16'h3333;
    nextMask   = 4'hF;
    nextDp     = 4'b0000;
    nextBlink  = 4'b0000;
    nextLzs    = 1'b0;
    nextValid  = 1'b1;
    checkCycles(1);
    bus.load = 1'b0;
    checkCycles(FRAME_LEN);

    $display("[TB] reset pulsed mid-slot");
    checkCycles(11);
    rst       = 1'b1;
    curData   = '0;
    curMask   = '0;
    curDp     = '0;
    curBlink  = '0;
    curLzs    = 1'b0;
    nextValid = 1'b0;
    checkCycles(1);
    rst = 1'b0;
    checkCycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
